// File: rtl/router_pkt_src.sv
// rtl/router_pkt_src.sv - buffers a payload and sends one header/payload/parity router packet
// Optional macro ROUTER_PKT_SRC_PAR_CORRUPT_EN adds corrupt_par to flip parity bit 0.
module router_pkt_src #(
  parameter int MAX_LEN  = 63,
  parameter int IDLE_GAP = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] pay_len,
  input  logic [7:0] pay_data,
  input  logic       pay_vld,
  output logic       pay_rdy,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_vd,
  output logic       ready,
  output logic       tx_done,
  output logic       tx_err
`ifdef ROUTER_PKT_SRC_PAR_CORRUPT_EN
  ,
  input  logic       corrupt_par
`endif
);

  localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HDR, S_PAY, S_PAR, S_GAP} state_t;

  state_t      state, state_nx;
  logic [7:0]  mem [MAX_LEN];
  logic [5:0]  len_q, cnt, cnt_nx;
  logic [1:0]  dest_q;
  logic [7:0]  parity, parity_nx, par_out;
  logic [GW-1:0] gap_cnt, gap_nx;
  logic [7:0]  dout_nx;
  logic        vd_nx, done_nx, err_nx;
  logic        illegal, last;

  assign illegal = (pay_len == 6'd0) || ({1'b0, pay_len} > 7'(MAX_LEN)) || (dest_addr == 2'd3);
  assign last    = (cnt == len_q - 6'd1);
  assign ready   = (state == S_IDLE);
  assign pay_rdy = (state == S_LOAD);

`ifdef ROUTER_PKT_SRC_PAR_CORRUPT_EN
  logic corrupt_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                      corrupt_q <= 1'b0;
    else if (state == S_IDLE && start && !illegal)  corrupt_q <= corrupt_par;
  end
  assign par_out = parity ^ {7'd0, corrupt_q};
`else
  assign par_out = parity;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start && !illegal) state_nx = S_LOAD;
      S_LOAD: if (pay_vld && last)   state_nx = S_HDR;
      S_HDR:  if (!busy)             state_nx = S_PAY;
      S_PAY:  if (!busy && last)     state_nx = S_PAR;
      S_PAR:  if (!busy)             state_nx = S_GAP;
      S_GAP:  if (gap_cnt == GW'(IDLE_GAP - 1)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered: each byte is loaded on the edge that enters its state.
  always_comb begin
    dout_nx   = data_out;
    vd_nx     = pkt_vd;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    cnt_nx    = cnt;
    parity_nx = parity;
    gap_nx    = gap_cnt;
    case (state)
      S_IDLE: if (start) begin
        if (illegal) err_nx = 1'b1;
        else begin
          parity_nx = {pay_len, dest_addr};
          cnt_nx    = 6'd0;
        end
      end
      S_LOAD: if (pay_vld) begin
        parity_nx = parity ^ pay_data;
        if (last) begin
          cnt_nx  = 6'd0;
          dout_nx = {len_q, dest_q};
          vd_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + 6'd1;
        end
      end
      S_HDR: if (!busy) dout_nx = mem[6'd0];
      S_PAY: if (!busy) begin
        if (last) begin
          cnt_nx  = 6'd0;
          dout_nx = par_out;
          vd_nx   = 1'b0;
        end else begin
          cnt_nx  = cnt + 6'd1;
          dout_nx = mem[cnt + 6'd1];
        end
      end
      S_PAR: if (!busy) begin
        dout_nx = 8'd0;
        done_nx = 1'b1;
        gap_nx  = '0;
      end
      S_GAP: gap_nx = gap_cnt + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out <= 8'd0;
      pkt_vd   <= 1'b0;
      tx_done  <= 1'b0;
      tx_err   <= 1'b0;
      cnt      <= 6'd0;
      parity   <= 8'd0;
      gap_cnt  <= '0;
      len_q    <= 6'd0;
      dest_q   <= 2'd0;
    end else begin
      data_out <= dout_nx;
      pkt_vd   <= vd_nx;
      tx_done  <= done_nx;
      tx_err   <= err_nx;
      cnt      <= cnt_nx;
      parity   <= parity_nx;
      gap_cnt  <= gap_nx;
      if (state == S_IDLE && start && !illegal) begin
        len_q  <= pay_len;
        dest_q <= dest_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_LOAD && pay_vld) mem[cnt] <= pay_data;
  end

endmodule

// File: tb/tb_router_pkt_src.sv
// tb/tb_router_pkt_src.sv - self-checking bench for router_pkt_src against a packet-level model
module tb_router_pkt_src;
  localparam int IDLE_GAP = 2;

  logic       clk = 1'b0;
  logic       rstn, start, pay_vld, busy;
  logic [1:0] dest_addr;
  logic [5:0] pay_len;
  logic [7:0] pay_data, data_out;
  logic       pay_rdy, pkt_vd, ready, tx_done, tx_err;
`ifdef ROUTER_PKT_SRC_PAR_CORRUPT_EN
  logic       corrupt_par;
  localparam bit HAS_CORRUPT = 1'b1;
`else
  localparam bit HAS_CORRUPT = 1'b0;
`endif

  int n_asserts = 0;
  int n_fails   = 0;
  logic [7:0] pay_q [64];

  always #5 clk = ~clk;

  router_pkt_src #(.MAX_LEN(63), .IDLE_GAP(IDLE_GAP)) dut (
    .clk(clk), .rstn(rstn), .start(start), .dest_addr(dest_addr), .pay_len(pay_len),
    .pay_data(pay_data), .pay_vld(pay_vld), .pay_rdy(pay_rdy), .busy(busy),
    .data_out(data_out), .pkt_vd(pkt_vd), .ready(ready), .tx_done(tx_done), .tx_err(tx_err)
`ifdef ROUTER_PKT_SRC_PAR_CORRUPT_EN
    , .corrupt_par(corrupt_par)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one packet from pay_q; the expected stream is derived from the packet format alone.
  task automatic send(input logic [1:0] d, input int l, input bit c, input int vld_mode,
                      input int busy_pct, input int stall_k, input int stall_n, input int abort_k);
    logic [7:0] exp [$];
    logic [7:0] p;
    int i, k, n, budget, stall_left;
    bit v, b, tog;
    chk("ready_before_start", ready, 8'd1);
    start = 1'b1; dest_addr = d; pay_len = 6'(l);
`ifdef ROUTER_PKT_SRC_PAR_CORRUPT_EN
    corrupt_par = c;
`endif
    step();
    chk("pay_rdy_load", pay_rdy, 8'd1);
    chk("ready_load", ready, 8'd0);
    p = 8'(l * 4 + d);
    exp.push_back(p);
    for (int j = 0; j < l; j++) begin
      exp.push_back(pay_q[j]);
      p = p ^ pay_q[j];
    end
    if (c && HAS_CORRUPT) p = p ^ 8'h01;
    exp.push_back(p);

    i = 0; budget = 0; tog = 1'b1;
    while (i < l && budget < 2000) begin
      v = (vld_mode == 0) ? 1'b1 : (vld_mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      pay_vld  = v;
      pay_data = v ? pay_q[i] : 8'($urandom);
      start    = 1'($urandom_range(0, 1));
      busy     = 1'($urandom_range(0, 1));
      step();
      budget++;
      if (v) i++;
      if (i < l) chk("pay_rdy_hold", pay_rdy, 8'd1);
    end
    pay_vld = 1'b0; start = 1'b0; busy = 1'b0;
    chk("load_done", 8'(i), 8'(l));
    chk("pay_rdy_after", pay_rdy, 8'd0);

    k = 0; n = l + 2; budget = 0; stall_left = stall_n;
    while (k < n && budget < 3000) begin
      if (k == abort_k) return;
      chk("data_out", data_out, exp[k]);
      chk("pkt_vd", pkt_vd, 8'(k < n - 1));
      chk("tx_done_low", tx_done, 8'd0);
      if (k == stall_k && stall_left > 0) begin
        b = 1'b1;
        stall_left--;
      end else begin
        b = ($urandom_range(0, 99) < busy_pct);
      end
      busy = b;
      step();
      budget++;
      if (!b) k++;
    end
    busy = 1'b0;
    chk("byte_count", 8'(k), 8'(n));
    chk("tx_done", tx_done, 8'd1);
    chk("gap_vd", pkt_vd, 8'd0);
    chk("gap_data", data_out, 8'd0);
    chk("gap_ready", ready, 8'd0);
    for (int g = 1; g < IDLE_GAP; g++) begin
      step();
      chk("gap_done_low", tx_done, 8'd0);
      chk("gap_vd_low", pkt_vd, 8'd0);
      chk("gap_not_ready", ready, 8'd0);
    end
    step();
    chk("ready_after_gap", ready, 8'd1);
    chk("idle_vd", pkt_vd, 8'd0);
  endtask

  task automatic bad_start(input logic [1:0] d, input logic [5:0] l);
    start = 1'b1; dest_addr = d; pay_len = l;
    step();
    start = 1'b0;
    chk("tx_err_pulse", tx_err, 8'd1);
    chk("err_ready", ready, 8'd1);
    chk("err_pay_rdy", pay_rdy, 8'd0);
    chk("err_vd", pkt_vd, 8'd0);
    step();
    chk("tx_err_clear", tx_err, 8'd0);
    chk("err_ready2", ready, 8'd1);
    chk("err_vd2", pkt_vd, 8'd0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; pay_vld = 1'b0; busy = 1'b0;
    dest_addr = 2'd0; pay_len = 6'd0; pay_data = 8'd0;
`ifdef ROUTER_PKT_SRC_PAR_CORRUPT_EN
    corrupt_par = 1'b0;
`endif
    step(); step();
    chk("rst_data_out", data_out, 8'd0);
    chk("rst_pkt_vd", pkt_vd, 8'd0);
    chk("rst_ready", ready, 8'd1);
    chk("rst_pay_rdy", pay_rdy, 8'd0);
    chk("rst_tx_done", tx_done, 8'd0);
    chk("rst_tx_err", tx_err, 8'd0);
    rstn = 1'b1;
    step();

    pay_q[0] = 8'h11; pay_q[1] = 8'h22; pay_q[2] = 8'h33;
    send(2'd1, 3, 1'b1, 0, 0, -1, 0, -1);
    send(2'd1, 3, 1'b0, 0, 0, 2, 3, -1);

    bad_start(2'd1, 6'd0);
    bad_start(2'd3, 6'd5);

    for (int j = 0; j < 63; j++) pay_q[j] = 8'hFF;
    send(2'd2, 63, 1'b0, 1, 0, 64, 2, -1);

    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 63; j++) pay_q[j] = 8'($urandom);
      send(2'($urandom_range(0, 2)), $urandom_range(1, 63), 1'($urandom_range(0, 1)),
           2, 30, (r == 0) ? 0 : -1, 2, -1);
    end

    for (int j = 0; j < 4; j++) pay_q[j] = 8'($urandom);
    send(2'd0, 4, 1'b0, 0, 0, -1, 0, 3);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_vd", pkt_vd, 8'd0);
    chk("async_rst_data", data_out, 8'd0);
    chk("async_rst_ready", ready, 8'd1);
    chk("async_rst_pay_rdy", pay_rdy, 8'd0);
    step();
    rstn = 1'b1;
    step();
    chk("post_rst_ready", ready, 8'd1);
    for (int j = 0; j < 5; j++) pay_q[j] = 8'($urandom);
    send(2'd2, 5, 1'b0, 2, 20, -1, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule

// File: doc/router_pkt_src.md
Name: router_pkt_src

Overview:
- Packet transmitter for the 1x3 router input port; the other end of the router's packet register and parity checker.
- Buffers a payload from an upstream byte stream, then emits one router packet: header byte, payload bytes, parity byte.
- Drives the router-side data/pkt_vd pair and honours the router's busy back-pressure.

Parameters:
- MAX_LEN, 63, maximum payload length in bytes; sets buffer depth; must be <= 63 (6-bit length field).
- IDLE_GAP, 2, minimum idle cycles with pkt_vd=0 between packets (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request a packet; sampled only when ready=1.
- dest_addr  input  2  destination port 0..2; 3 is illegal.
- pay_len  input  6  payload length 1..MAX_LEN.
- pay_data  input  8  upstream payload byte.
- pay_vld  input  1  pay_data valid.
- pay_rdy  output  1  block accepts pay_data this cycle.
- busy  input  1  router busy; presented byte not taken while high.
- data_out  output  8  byte to router (registered).
- pkt_vd  output  1  packet valid to router (registered).
- ready  output  1  idle, start accepted.
- tx_done  output  1  one-cycle pulse after the parity byte transfers.
- tx_err  output  1  one-cycle pulse on an illegal start.

Behaviour:
- Reset (async, any state): state=IDLE; data_out=0, pkt_vd=0, pay_rdy=0, tx_done=0, tx_err=0, ready=1. Byte counter=0, parity=0. Buffer contents are don't-care.
- States: IDLE, LOAD, HDR, PAY, PAR, GAP.
- IDLE: ready=1. On start=1:
  - If pay_len==0, pay_len>MAX_LEN or dest_addr==3: tx_err=1 next cycle, stay in IDLE.
  - Otherwise latch len and dest, header={pay_len,dest_addr}, parity<=header, and go to LOAD.
- LOAD: pay_rdy=1. Each pay_vld&pay_rdy edge writes buf[cnt], updates parity^=pay_data and increments cnt. Gaps in pay_vld simply wait. After the len-th byte: pay_rdy=0, cnt=0, go to HDR. ready=0 in all non-IDLE states.
- HDR/PAY/PAR present one byte each:
  - HDR: data_out=header, pkt_vd=1.
  - PAY: data_out=buf[cnt], pkt_vd=1.
  - PAR: data_out=parity, pkt_vd=0.
- The presented byte appears on the cycle after entering the state. It transfers on the first rising edge with busy=0, and the next byte is presented the following cycle. While busy=1, data_out and pkt_vd hold unchanged.
- Transitions:
  - HDR -> PAY on transfer.
  - PAY stays in PAY, cnt++, until the byte at cnt==len-1 transfers, then -> PAR.
  - PAR -> GAP on transfer; tx_done=1 the next cycle.
  - GAP: pkt_vd=0, data_out=0 for IDLE_GAP cycles, then -> IDLE.
- Parity = XOR of header and all payload bytes, 8-bit, computed during LOAD.
- pkt_vd falls exactly when the parity byte is presented. pkt_vd is never high outside HDR/PAY.
- start outside IDLE is ignored. pay_vld outside LOAD is ignored.
- busy rising in the same cycle as a state entry: the byte is held from its first presented cycle.

Optional Feature:
- Macro: ROUTER_PKT_SRC_PAR_CORRUPT_EN.
- With the macro: adds input corrupt_par (1 bit), latched with start. When latched high, the transmitted parity byte has bit 0 inverted, for router error-path testing.
- Without the macro: the port is absent and parity is always correct.

Test Plan:
- dest=1, len=3, payload 0x11,0x22,0x33, busy=0 -> data_out sequence 0x0D,0x11,0x22,0x33 with pkt_vd=1, then 0x0D with pkt_vd=0; tx_done pulse; pkt_vd low for >=2 cycles; then ready=1.
- Same packet, busy=1 for 3 cycles while 0x22 is presented -> 0x22 and pkt_vd=1 held all 3 cycles, then 0x33; no byte lost or duplicated.
- start with len=0, then start with dest=3 -> one tx_err pulse each; pkt_vd stays 0; pay_rdy stays 0; ready stays 1.
- dest=2, len=63, all payload 0xFF, pay_vld toggling every other cycle -> header 0xFE, 63 bytes of 0xFF, parity 0x01.
- rstn asserted mid-PAY -> pkt_vd=0, data_out=0 asynchronously; after release ready=1 and a new packet sends correctly.
- With ROUTER_PKT_SRC_PAR_CORRUPT_EN and corrupt_par=1 on the first packet -> parity byte 0x0C instead of 0x0D; the next packet with corrupt_par=0 has correct parity.
